// File: rtl/bus_pkg.sv
// Shared types and constants for the bus target receiver.
package bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic ACK   = 1'b1;
    localparam logic NAK   = 1'b0;
    localparam int   CNT_W = 8;

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_target_rx_if.sv
// Bus-side and consumer-side signals of the receive target, bundled with modports.
interface bus_target_rx_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
);
    logic                       bus_strobe;
    logic [ADDR_W-1:0]          bus_addr;
    logic [WIDTH-1:0]           bus_data;
    logic                       bus_par;
    logic                       bus_ack_oe;
    logic                       bus_ack;
    logic [WIDTH-1:0]           rd_data;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [7:0]                 par_err_cnt;
    logic [7:0]                 ovf_cnt;

    modport slave (
        input  bus_strobe, bus_addr, bus_data, bus_par, rd_ready,
        output bus_ack_oe, bus_ack, rd_data, rd_valid, fifo_count,
               par_err_cnt, ovf_cnt
    );

    modport master (
        output bus_strobe, bus_addr, bus_data, bus_par, rd_ready,
        input  bus_ack_oe, bus_ack, rd_data, rd_valid, fifo_count,
               par_err_cnt, ovf_cnt
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, pointers and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == {CNT_W{1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and count; blocked push/pop are dropped here
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;

        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_target_rx.sv
// Receive target on the shared bus: address match, even-parity check, FIFO capture
// and a registered ACK/NAK response held for the rest of the strobe.
module bus_target_rx
    import bus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int MY_ADDR = 0,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_target_rx_if.slave  bif
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;

    function automatic logic even_par_ok(input logic [WIDTH-1:0] d, input logic p);
        return ((^d) ^ p) == 1'b0;
    endfunction

    state_t              state_q, state_d;
    logic                ack_oe_q, ack_oe_d;
    logic                ack_q, ack_d;
    logic [CNT_W-1:0]    par_err_q, par_err_d;
    logic [CNT_W-1:0]    ovf_q, ovf_d;

    logic                addr_hit_s;
    logic                par_ok_s;
    logic                push_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [WIDTH-1:0]    fifo_head_s;
    logic [FCNT_W-1:0]   fifo_count_s;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (bif.bus_data),
        .pop       (bif.rd_ready),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign addr_hit_s = bif.bus_strobe && (bif.bus_addr == ADDR_W'(MY_ADDR));
    assign par_ok_s   = even_par_ok(bif.bus_data, bif.bus_par);

    // Response FSM; the full test sees start-of-cycle occupancy, so a same-cycle pop cannot rescue a capture
    always_comb begin
        state_d   = state_q;
        ack_oe_d  = ack_oe_q;
        ack_d     = ack_q;
        par_err_d = par_err_q;
        ovf_d     = ovf_q;
        push_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (addr_hit_s) begin
                    state_d  = RESP;
                    ack_oe_d = 1'b1;
                    if (!par_ok_s) begin
                        ack_d     = NAK;
                        par_err_d = sat_inc(par_err_q);
                    end else if (fifo_full_s) begin
                        ack_d = NAK;
                        ovf_d = sat_inc(ovf_q);
                    end else begin
                        ack_d  = ACK;
                        push_s = 1'b1;
                    end
                end else begin
                    ack_oe_d = 1'b0;
                end
            end
            RESP: begin
                if (!bif.bus_strobe) begin
                    state_d  = IDLE;
                    ack_oe_d = 1'b0;
                end else begin
                    ack_oe_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                ack_oe_d = 1'b0;
            end
        endcase
    end

    // FSM, response and error-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ack_oe_q  <= 1'b0;
            ack_q     <= NAK;
            par_err_q <= {CNT_W{1'b0}};
            ovf_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ack_oe_q  <= ack_oe_d;
            ack_q     <= ack_d;
            par_err_q <= par_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bif.bus_ack_oe  = ack_oe_q;
    assign bif.bus_ack     = ack_q;
    assign bif.rd_data     = fifo_head_s;
    assign bif.rd_valid    = !fifo_empty_s;
    assign bif.fifo_count  = fifo_count_s;
    assign bif.par_err_cnt = par_err_q;
    assign bif.ovf_cnt     = ovf_q;

endmodule

// File: doc/bus_target_rx.md
# bus_target_rx

Receive end of the shared tri-state data bus. Senders drive data, parity and address onto the bus through `tri_buffer` instances. This block watches the bus and recognises transfers addressed to `MY_ADDR`. It checks even parity, buffers accepted words in a small FIFO, and returns an ACK/NAK response that the top level drives back onto the shared ack line through its own `tri_buffer`.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `ADDR_W`, 4: bus address width.
- `MY_ADDR`, 0: address this target responds to.
- `DEPTH`, 4: FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk` input 1: single clock; all bus inputs are synchronous to it.
- `rst_n` input 1: reset, asynchronous and active-low.
- `bus_strobe` input 1: sender asserts it while addr/data/par are stable.
- `bus_addr` input ADDR_W: target address.
- `bus_data` input WIDTH: payload.
- `bus_par` input 1: even-parity bit; `^{bus_data,bus_par}` must be 0.
- `bus_ack_oe` output 1: enable for the external ack `tri_buffer`.
- `bus_ack` output 1: 1 = ACK (word stored), 0 = NAK (word dropped).
- `rd_data` output WIDTH: FIFO head.
- `rd_valid` output 1: FIFO non-empty.
- `rd_ready` input 1: consumer pops the head when `rd_valid && rd_ready`.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy.
- `par_err_cnt` output 8: saturating count of parity NAKs.
- `ovf_cnt` output 8: saturating count of full-FIFO NAKs.

## Operation
- FSM states: IDLE, RESP.
- IDLE to RESP: `bus_strobe && bus_addr==MY_ADDR` sampled high.
  - Capture decision is made in that cycle, in this priority order.
  - Parity bad: NAK and increment `par_err_cnt`.
  - Parity good and `fifo_count==DEPTH`: NAK and increment `ovf_cnt`.
  - Otherwise: push `bus_data` and ACK.
- The full check uses the occupancy at the start of the cycle. A simultaneous pop does not free a slot for that capture.
- When parity is bad and the FIFO is also full, only `par_err_cnt` increments.
- RESP: hold `bus_ack_oe=1` with the registered response while `bus_strobe` stays high. The sampled word is never re-captured.
- RESP to IDLE: `bus_strobe` sampled low. `bus_ack_oe` drops on the next edge.
- Strobes addressed to other targets are ignored entirely: no state change, no counters, `bus_ack_oe` stays 0.
- A new transfer is only recognised from IDLE. A strobe that stays high is never a second transfer.
- FIFO is first-in first-out:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- Counters saturate at 255 and never wrap.
- Reset values: state IDLE, `bus_ack_oe=0`, `bus_ack=0`, FIFO empty, `rd_valid=0`, `fifo_count=0`, both counters 0.
  - `rd_data` is don't-care while `rd_valid=0`.
- Reset asserted mid-transfer: `bus_ack_oe` drops immediately (asynchronous), FIFO contents are discarded, counters are cleared.

## Timing
- Capture cycle N (IDLE, addressed strobe):
  - `bus_ack_oe` and `bus_ack` are registered and valid from cycle N+1.
  - On ACK, the word is visible at `rd_data` with `rd_valid=1` from cycle N+1 if the FIFO was empty.
  - On ACK, `fifo_count` increments at N+1.
  - On NAK, the relevant counter increments at N+1.
- Strobe sampled low in cycle M: `bus_ack_oe=0` from M+1; IDLE from M+1.
- The earliest next capture is at M+1, so the minimum transfer is 2 cycles with the strobe high and 1 cycle low.
- `rd_valid`, `rd_data` and `fifo_count` are registered. A pop at edge K updates them at K+1.
- No combinational path from any bus input to any output.

## Structure
- Package `bus_pkg`:
  - state enum `{IDLE, RESP}`.
  - `ACK=1'b1`, `NAK=1'b0` constants.
  - counter width constant `CNT_W=8`.
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH:
  - push/pop/full/empty/count interface.
  - `bus_target_rx` instantiates it once.
- FSM, parity check and saturating counters live in `bus_target_rx`.

## Test plan
- **Single ACK:** MY_ADDR=3; strobe with addr=3, data=0xA5, par=0 (even) -> `bus_ack_oe=1` and `bus_ack=1` at N+1; `rd_data=0xA5`, `rd_valid=1`, `fifo_count=1`.
- **Parity NAK:** addr=3, data=0xA5, par=1 -> `bus_ack=0`; `par_err_cnt=1`; `fifo_count` stays 0.
- **Overflow and ordering:** DEPTH=4; five transfers 0x01..0x05 with `rd_ready=0` -> first four ACK, fifth NAK; `ovf_cnt=1`. Then hold `rd_ready=1` -> pops return 0x01,0x02,0x03,0x04; `rd_valid=0` after the fourth.
- **Foreign address and held strobe:** addr=5 -> `bus_ack_oe` never asserts, no counter change. Then a strobe to addr=3 held high for 10 cycles -> exactly one push; `bus_ack_oe` drops one cycle after the strobe falls.
- **Full with simultaneous pop:** FIFO full, `rd_ready=1` in the capture cycle -> NAK, `ovf_cnt` increments, `fifo_count` goes 4->3.
- **Reset mid-RESP, then saturation:**
  - Assert `rst_n=0` during RESP with 2 words queued -> `bus_ack_oe=0` immediately; `fifo_count=0`; counters 0.
  - After release, 300 parity-error transfers -> `par_err_cnt=255`.
